// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: loads a cipher key and streams round keys 0..NR
// over a valid/ready handshake, producing each next key in a single cycle.
module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_reg, state_next;
    logic [127:0] key_reg, key_next;
    logic [3:0]   idx_reg, idx_next;
    logic [7:0]   rcon_reg, rcon_next;
    logic         valid_reg, valid_next;
    logic         busy_reg, busy_next;
    logic         done_reg, done_next;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // FIPS-197 S-box built from its definition: GF(2^8) inverse (a^254, 0 maps to 0)
    // followed by the affine transform, so no 256-entry constant table is needed.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gf_mul(inv, base);
            base = gf_mul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_word, sub_word, t_word;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [127:0] next_key;

    assign {w0, w1, w2, w3} = key_reg;
    assign rot_word = {w3[23:0], w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

    assign t_word   = sub_word ^ {rcon_reg, 24'h0};
    assign w0_n     = w0 ^ t_word;
    assign w1_n     = w1 ^ w0_n;
    assign w2_n     = w2 ^ w1_n;
    assign w3_n     = w3 ^ w2_n;
    assign next_key = {w0_n, w1_n, w2_n, w3_n};

    // start wins in either state; in RUN it discards any transfer of the same cycle.
    always_comb begin
        state_next = state_reg;
        key_next   = key_reg;
        idx_next   = idx_reg;
        rcon_next  = rcon_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        if (start) begin
            state_next = RUN;
            key_next   = key_in;
            idx_next   = 4'd0;
            rcon_next  = 8'h01;
            valid_next = 1'b1;
            busy_next  = 1'b1;
        end else if (state_reg == RUN && valid_reg && key_ready) begin
            if (idx_reg == LAST_IDX) begin
                state_next = IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end else begin
                key_next  = next_key;
                idx_next  = idx_reg + 4'd1;
                rcon_next = xtime(rcon_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            key_reg   <= '0;
            idx_reg   <= '0;
            rcon_reg  <= 8'h01;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            key_reg   <= key_next;
            idx_reg   <= idx_next;
            rcon_reg  <= rcon_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign round_key = key_reg;
    assign round_idx = idx_reg;
    assign key_valid = valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 and all-zero key expansions,
// stalls, restart, mid-run reset, reset/start collision and start on done.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready = 1'b0;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    aes_key_schedule #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    vec_t vec [22];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All actions happen on the falling edge; the DUT samples on the rising edge.
    task automatic do_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " key"},   round_key, 128'h0);
        check({tag, " idx"},   round_idx, 4'd0);
        check({tag, " valid"}, key_valid, 1'b0);
        check({tag, " busy"},  busy,      1'b0);
        check({tag, " done"},  done,      1'b0);
    endtask

    task automatic check_round(input string tag, input int v);
        check($sformatf("%s r%0d valid", tag, vec[v].idx), key_valid, 1'b1);
        check($sformatf("%s r%0d busy",  tag, vec[v].idx), busy,      1'b1);
        check($sformatf("%s r%0d done",  tag, vec[v].idx), done,      1'b0);
        check($sformatf("%s r%0d idx",   tag, vec[v].idx), round_idx, vec[v].idx);
        check($sformatf("%s r%0d key",   tag, vec[v].idx), round_key, vec[v].exp);
    endtask

    // Entered on the cycle where round 'first' is presented; streams through round 10,
    // then checks the done pulse. With chain set, a new start is issued on the done cycle.
    task automatic run_keys(input string tag, input int base, input int first, input bit stalls,
                            input bit chain, input logic [127:0] chain_key);
        int s;
        for (int k = first; k <= 10; k++) begin
            check_round(tag, base + k);
            if (stalls) begin
                s = $urandom_range(0, 5);
                key_ready = 1'b0;
                for (int j = 0; j < s; j++) begin
                    @(negedge clk);
                    check_round({tag, " stall"}, base + k);
                end
            end
            key_ready = 1'b1;
            $display("%s: round %0d key %h", tag, round_idx, round_key);
            @(negedge clk);
        end
        check({tag, " done pulse"},  done,      1'b1);
        check({tag, " done valid"},  key_valid, 1'b0);
        check({tag, " done busy"},   busy,      1'b0);
        check({tag, " held idx"},    round_idx, 4'd10);
        check({tag, " held key"},    round_key, vec[base + 10].exp);
        if (chain) begin
            do_start(chain_key);
        end else begin
            @(negedge clk);
            check({tag, " done one cycle"}, done, 1'b0);
        end
    endtask

    initial begin
        logic [127:0] fips_exp [11];
        logic [127:0] zero_exp [11];
        fips_exp = '{
            128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
            128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
            128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
            128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
            128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        zero_exp = '{
            128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
            128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
            128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
            128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
            128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
            128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        for (int i = 0; i < 11; i++) begin
            vec[i]      = '{FIPS_KEY, 4'(i), fips_exp[i]};
            vec[11 + i] = '{ZERO_KEY, 4'(i), zero_exp[i]};
        end

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        check("reset still idle", key_valid, 1'b0);

        // 1: FIPS key, ready held high, 11 keys back-to-back
        key_ready = 1'b1;
        do_start(vec[0].key);
        run_keys("fips", 0, 0, 1'b0, 1'b0, '0);

        // 2: all-zero key
        do_start(vec[11].key);
        run_keys("zero", 11, 0, 1'b0, 1'b0, '0);

        // 3: FIPS key with random stalls
        do_start(vec[0].key);
        run_keys("fips_stall", 0, 0, 1'b1, 1'b0, '0);

        // 4: restart at round 4 with the zero key; the transfer that cycle is dropped
        do_start(FIPS_KEY);
        for (int k = 0; k < 4; k++) begin
            check_round("abort", k);
            @(negedge clk);
        end
        check_round("abort", 4);
        do_start(ZERO_KEY);
        run_keys("restart", 11, 0, 1'b0, 1'b0, '0);

        // 5: reset at round 6, then a fresh FIPS schedule
        do_start(FIPS_KEY);
        for (int k = 0; k < 6; k++) begin
            check_round("pre_rst", k);
            @(negedge clk);
        end
        check_round("pre_rst", 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_rst");
        do_start(FIPS_KEY);
        run_keys("post_rst", 0, 0, 1'b0, 1'b0, '0);

        // 6: reset and start together: reset wins
        rst    = 1'b1;
        start  = 1'b1;
        key_in = FIPS_KEY;
        @(negedge clk);
        start  = 1'b0;
        rst    = 1'b0;
        check_idle("rst_start");
        @(negedge clk);
        check_idle("rst_start hold");

        // start on the done cycle launches a new schedule
        do_start(FIPS_KEY);
        run_keys("chain_a", 0, 0, 1'b0, 1'b1, ZERO_KEY);
        run_keys("chain_b", 11, 0, 1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Iterative AES-128 key expansion stage. It sits directly upstream of the encryption round datapath and feeds its roundKey input. It loads a 128-bit cipher key and emits round keys 0..10 one at a time over a valid/ready handshake. Each next key is computed from the current one in a single cycle using four shared S-box byte lookups and an internal Rcon sequence.

Parameters:
NR, 10, number of rounds after round 0; only 10 (AES-128) is legal, other values are out of scope.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse; loads key_in and begins a schedule.
key_in  input  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0].
key_ready  input  1  consumer accepts round_key this cycle.
round_key  output  128  current round key, same word ordering as key_in.
round_idx  output  4  index of round_key, 0..10.
key_valid  output  1  round_key/round_idx valid.
busy  output  1  schedule in progress.
done  output  1  one-cycle pulse after round 10 key accepted.

Behaviour:
- Reset: key held in state IDLE; round_key=0, round_idx=0, key_valid=0, busy=0, done=0, Rcon register=8'h01. Reset dominates start.
- State IDLE:
  - On start: register key_in into round_key, set round_idx=0, Rcon=01, key_valid=1, busy=1, go to RUN.
  - Latency from start to key_valid is 1 cycle.
- State RUN: a transfer occurs on key_valid && key_ready.
  - Transfer with round_idx<10: round_key <= next key, round_idx +1, Rcon <= xtime(Rcon). key_valid stays 1.
  - Back-to-back: one key per cycle with key_ready held high, giving 11 keys in 11 consecutive cycles.
  - Transfer with round_idx==10: key_valid=0, busy=0, done=1 for exactly one cycle, go to IDLE. round_key and round_idx hold their last values.
  - key_ready low: all outputs hold, no advance (stall of any length).
- Next-key function, with w0..w3 from round_key:
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}, where RotWord rotates bytes left by one ({b1,b2,b3,b0}).
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- Rcon sequence by produced round 1..10: 01,02,04,08,10,20,40,80,1B,36.
  - xtime is a left shift by 1, XOR 8'h1B if the msb was 1.
- start while busy: restart. Reload key_in, round_idx=0, Rcon=01, key_valid=1. A transfer in that same cycle is discarded and done is not asserted.
- start in the same cycle as done: accepted as a new schedule. done still pulses that cycle.
- S-box is the standard FIPS-197 table, combinational, 4 instances; no external memory.
- done and key_valid are never high in the same cycle.

Test Plan:
1. Key 2b7e151628aed2a6abf7158809cf4f3c, key_ready=1 constant. Required response:
   - round 0 = the key itself.
   - round 1 = a0fafe1788542cb123a339392a6c7605.
   - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - 11 consecutive valid cycles, then a done pulse.
2. All-zero key. Required response:
   - round 1 = 62636363626363636263636362636363.
   - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
3. FIPS key with key_ready toggled randomly (stall 0-5 cycles). Required response:
   - Identical key sequence to scenario 1.
   - round_key/round_idx stable during stalls.
   - done only after the idx-10 transfer.
4. start reissued at round_idx=4 with the zero key. Required response:
   - Next cycle round_idx=0 and round_key=0.
   - Sequence continues as scenario 2.
   - No done from the aborted run.
5. rst asserted at round_idx=6. Required response:
   - Next cycle all outputs zero and state IDLE.
   - A later start with the FIPS key yields the scenario 1 keys, confirming Rcon was reset.
6. start and rst high together. Required response:
   - Outputs stay at reset values and key_valid=0.
